// File: rtl/fetch_queue.sv
// Pipelined instruction fetch: several icache requests in flight, BTB steering at issue,
// and an instruction FIFO toward decode. Squashed returns are swallowed by a drop counter.
module fetch_queue #(
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        predicted_taken_out,
    output logic [31:0] predicted_target_out,
    output logic        icache_en_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_gnt_i,
    input  logic [31:0] icache_rdata_i,
    input  logic        icache_rvalid_i,
    output logic [31:0] btb_lookup_pc_o,
    input  logic        btb_lookup_hit_i,
    input  logic        btb_lookup_taken_i,
    input  logic [31:0] btb_lookup_target_i
);

    localparam int QPTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int QCNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int TPTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int ICNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SUM_W  = $clog2(QUEUE_DEPTH + MAX_OUTSTANDING + 1);

    localparam logic [ICNT_W-1:0] MAX_INFLIGHT = ICNT_W'(MAX_OUTSTANDING);
    localparam logic [SUM_W-1:0]  DEPTH_SUM    = SUM_W'(QUEUE_DEPTH);
    localparam logic [TPTR_W-1:0] TPTR_LAST    = TPTR_W'(MAX_OUTSTANDING - 1);

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] target;
    } tag_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
        logic [31:0] target;
    } entry_t;

    // Request tags, in issue order; returns arrive in the same order
    tag_t              tag_mem [MAX_OUTSTANDING];
    logic [TPTR_W-1:0] tag_wr_reg;
    logic [TPTR_W-1:0] tag_rd_reg;

    entry_t            q_mem [QUEUE_DEPTH];
    logic [QPTR_W-1:0] q_wr_reg;
    logic [QPTR_W-1:0] q_rd_reg;
    logic [QCNT_W-1:0] q_count_reg;
    logic [QCNT_W-1:0] q_count_next;

    logic [ICNT_W-1:0] inflight_reg;
    logic [ICNT_W-1:0] inflight_next;
    logic [ICNT_W-1:0] drop_reg;
    logic [ICNT_W-1:0] drop_next;
    logic [31:0]       pc_reg;
    logic [31:0]       pc_next;

    tag_t              tag_head;
    entry_t            q_head;
    logic [6:0]        opcode;
    logic              is_cf;
    logic              has_drop;
    logic              ret_live;
    logic              redirect_now;
    logic [SUM_W-1:0]  credit_sum;
    logic              issue;
    logic              accept;
    logic              btb_pred;
    logic              enq;
    logic              pop;
    logic [ICNT_W-1:0] inflight_after_pop;

    function automatic logic [TPTR_W-1:0] tag_ptr_inc(input logic [TPTR_W-1:0] p);
        return (p == TPTR_LAST) ? '0 : p + TPTR_W'(1);
    endfunction

    assign tag_head = tag_mem[tag_rd_reg];
    assign q_head   = q_mem[q_rd_reg];

    // Branches, JAL and JALR are the only opcodes a BTB hit may legitimately steer
    assign opcode = icache_rdata_i[6:0];
    assign is_cf  = (opcode == 7'b1100011) || (opcode == 7'b1101111) || (opcode == 7'b1100111);

    assign has_drop     = (drop_reg != '0);
    assign ret_live     = icache_rvalid_i && !has_drop && !flush_i;
    assign redirect_now = ret_live && tag_head.pred && !is_cf;

    // Every in-flight request already owns a queue slot, so returns can never overflow
    assign credit_sum = SUM_W'(inflight_reg) + SUM_W'(q_count_reg);
    assign issue      = !rst && !flush_i && !redirect_now
                        && (inflight_reg < MAX_INFLIGHT) && (credit_sum < DEPTH_SUM);
    assign accept     = issue && icache_gnt_i;
    assign btb_pred   = btb_lookup_hit_i && btb_lookup_taken_i;

    assign valid_out = (q_count_reg != '0);
    assign enq       = ret_live;
    assign pop       = valid_out && ready_in && !flush_i;

    assign inflight_after_pop = inflight_reg - ICNT_W'(icache_rvalid_i);

    always_comb begin
        inflight_next = inflight_after_pop + ICNT_W'(accept);
        drop_next     = drop_reg;
        pc_next       = pc_reg;
        q_count_next  = q_count_reg;
        if (flush_i) begin
            pc_next      = flush_pc_i;
            drop_next    = inflight_after_pop;
            q_count_next = '0;
        end else begin
            if (accept) begin
                pc_next = btb_pred ? btb_lookup_target_i : pc_reg + 32'd4;
            end
            if (redirect_now) begin
                // Everything issued after the mispredicted fetch is wrong-path
                pc_next   = tag_head.pc + 32'd4;
                drop_next = inflight_after_pop;
            end else if (icache_rvalid_i && has_drop) begin
                drop_next = drop_reg - ICNT_W'(1);
            end
            q_count_next = q_count_reg + QCNT_W'(enq) - QCNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            inflight_reg <= '0;
            drop_reg     <= '0;
            q_count_reg  <= '0;
            tag_wr_reg   <= '0;
            tag_rd_reg   <= '0;
            q_wr_reg     <= '0;
            q_rd_reg     <= '0;
        end else begin
            pc_reg       <= pc_next;
            inflight_reg <= inflight_next;
            drop_reg     <= drop_next;
            q_count_reg  <= q_count_next;
            if (accept) begin
                tag_wr_reg <= tag_ptr_inc(tag_wr_reg);
            end
            if (icache_rvalid_i) begin
                tag_rd_reg <= tag_ptr_inc(tag_rd_reg);
            end
            if (flush_i) begin
                q_wr_reg <= '0;
                q_rd_reg <= '0;
            end else begin
                if (enq) begin
                    q_wr_reg <= q_wr_reg + QPTR_W'(1);
                end
                if (pop) begin
                    q_rd_reg <= q_rd_reg + QPTR_W'(1);
                end
            end
        end
    end

    // Payload storage carries no reset; pointers and counts alone define validity
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wr_reg] <= '{pc: pc_reg, pred: btb_pred, target: btb_lookup_target_i};
        end
        if (enq) begin
            q_mem[q_wr_reg] <= '{pc:     tag_head.pc,
                                 instr:  icache_rdata_i,
                                 pred:   tag_head.pred && is_cf,
                                 target: (tag_head.pred && is_cf) ? tag_head.target : 32'd0};
        end
    end

    assign icache_en_o     = issue;
    assign icache_addr_o   = pc_reg;
    assign btb_lookup_pc_o = pc_reg;

    assign pc_out               = valid_out ? q_head.pc     : 32'd0;
    assign instr_out            = valid_out ? q_head.instr  : 32'd0;
    assign predicted_taken_out  = valid_out && q_head.pred;
    assign predicted_target_out = valid_out ? q_head.target : 32'd0;

    rvalid_needs_inflight: assert property (@(posedge clk) disable iff (rst)
        !(icache_rvalid_i && (inflight_reg == '0)));

endmodule
